// File: rtl/operand_pkg.sv
// operand_pkg: shared widths, FSM state encoding and shift codes for the operand-fetch stage.
package operand_pkg;
   localparam int DW = 16;
   localparam int NREG = 8;
   typedef enum logic [1:0] {IDLE, RD_A, RD_B, HOLD} state_t;
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL = 2'b01;
   localparam logic [1:0] SH_LSR = 2'b10;
   localparam logic [1:0] SH_ASR = 2'b11;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: command, writeback and operand handshake bundle; master drives commands, slave is the fetch stage.
interface operand_fetch_if #(parameter int DW = operand_pkg::DW, parameter int NREG = operand_pkg::NREG);
   localparam int AW = $clog2(NREG);
   logic start;
   logic [AW-1:0] rn;
   logic [AW-1:0] rm;
   logic [1:0] shift;
   logic use_imm;
   logic [4:0] imm;
   logic zero_a;
   logic wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic busy;
   logic op_valid;
   logic op_ready;
   logic [DW-1:0] ain;
   logic [DW-1:0] bin;
   modport master (output start, rn, rm, shift, use_imm, imm, zero_a, wr_en, wr_addr, wr_data, op_ready,
                   input busy, op_valid, ain, bin);
   modport slave (input start, rn, rm, shift, use_imm, imm, zero_a, wr_en, wr_addr, wr_data, op_ready,
                  output busy, op_valid, ain, bin);
endinterface

// File: rtl/operand_fetch_regfile.sv
// regfile: NREG x DW register file, one synchronous write port, two combinational read ports, sync active-low clear.
module regfile #(parameter int DW = 16, parameter int NREG = 8, localparam int AW = $clog2(NREG)) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] ra_addr,
   output logic [DW-1:0] ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] rb_data
);
   logic [DW-1:0] mem_q [NREG];
   always_ff @(posedge clk) begin
      if (!reset_n)
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      else if (wr_en)
         mem_q[wr_addr] <= wr_data;
   end
   assign ra_data = mem_q[ra_addr];
   assign rb_data = mem_q[rb_addr];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads A then B from the register file, applies shift/immediate, holds operands under valid/ready.
// Define OPERAND_BYPASS_EN to forward same-cycle writeback data into the A/B reads.
module operand_fetch import operand_pkg::*; #(parameter int DW = operand_pkg::DW, parameter int NREG = operand_pkg::NREG) (
   input logic clk,
   input logic reset_n,
   operand_fetch_if.slave bus
);
   localparam int AW = $clog2(NREG);
   state_t state_q, state_d;
   logic [AW-1:0] rn_q, rn_d, rm_q, rm_d;
   logic [1:0] sh_q, sh_d;
   logic ui_q, ui_d, za_q, za_d;
   logic [4:0] imm_q, imm_d;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic [DW-1:0] rf_a, rf_b, rd_a, rd_b, sh_b;
   logic take;

   regfile #(.DW(DW), .NREG(NREG)) u_rf (
      .clk(clk), .reset_n(reset_n),
      .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
      .ra_addr(rn_q), .ra_data(rf_a),
      .rb_addr(rm_q), .rb_data(rf_b)
   );

`ifdef OPERAND_BYPASS_EN
   assign rd_a = (bus.wr_en && bus.wr_addr == rn_q) ? bus.wr_data : rf_a;
   assign rd_b = (bus.wr_en && bus.wr_addr == rm_q) ? bus.wr_data : rf_b;
`else
   assign rd_a = rf_a;
   assign rd_b = rf_b;
`endif

   assign sh_b = sh_q == SH_NONE ? rd_b :
                 sh_q == SH_LSL  ? {rd_b[DW-2:0], 1'b0} :
                 sh_q == SH_LSR  ? {1'b0, rd_b[DW-1:1]} :
                                   {rd_b[DW-1], rd_b[DW-1:1]};
   // A new command is only taken from IDLE or on a completing handshake.
   assign take = bus.start && (state_q == IDLE || (state_q == HOLD && bus.op_ready));

   always_comb begin
      state_d = state_q;
      rn_d = take ? bus.rn : rn_q;
      rm_d = take ? bus.rm : rm_q;
      sh_d = take ? bus.shift : sh_q;
      ui_d = take ? bus.use_imm : ui_q;
      imm_d = take ? bus.imm : imm_q;
      za_d = take ? bus.zero_a : za_q;
      a_d = a_q;
      b_d = b_q;
      case (state_q)
         IDLE: state_d = take ? RD_A : IDLE;
         RD_A: begin
            a_d = rd_a;
            state_d = RD_B;
         end
         RD_B: begin
            b_d = ui_q ? {{(DW-5){imm_q[4]}}, imm_q} : sh_b;
            state_d = HOLD;
         end
         HOLD: state_d = !bus.op_ready ? HOLD : bus.start ? RD_A : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rn_q <= '0;
         rm_q <= '0;
         sh_q <= '0;
         ui_q <= 1'b0;
         imm_q <= '0;
         za_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         state_q <= state_d;
         rn_q <= rn_d;
         rm_q <= rm_d;
         sh_q <= sh_d;
         ui_q <= ui_d;
         imm_q <= imm_d;
         za_q <= za_d;
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign bus.busy = state_q != IDLE;
   assign bus.op_valid = state_q == HOLD;
   assign bus.ain = (state_q == HOLD && za_q) ? '0 : a_q;
   assign bus.bin = b_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch; expected operand pairs are queued at issue and compared at handshake.
module tb_operand_fetch;
   logic clk;
   logic reset_n;
   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] model [8];
   logic [31:0] sb [$];
   logic [31:0] e;
   logic [15:0] ha, hb;
`ifdef OPERAND_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   operand_fetch_if bus ();
   operand_fetch dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
      logic signed [15:0] s;
      s = v;
      case (sh)
         2'd1: return v << 1;
         2'd2: return v >> 1;
         2'd3: return s >>> 1;
         default: return v;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset_n && bus.op_valid && bus.op_ready) begin
         if (sb.size() == 0) check("sb_underflow", 1, 0);
         else begin
            e = sb.pop_front();
            check("ain", bus.ain, e[31:16]);
            check("bin", bus.bin, e[15:0]);
         end
      end
   end

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      @(posedge clk); #1 bus.wr_en = 1'b0;
      model[a] = d;
   endtask

   task automatic load(input logic [2:0] rn, rm, input logic [1:0] sh, input logic ui, input logic [4:0] im,
                       input logic za, input logic rdw, input logic [15:0] rdw_d, input logic push);
      logic [15:0] ea, eb;
      ea = (rdw && BYP) ? rdw_d : model[rn];
      if (za) ea = 16'h0;
      eb = ui ? {{11{im[4]}}, im} : shf(rdw && rm == rn ? rdw_d : model[rm], sh);
      if (push) sb.push_back({ea, eb});
      bus.rn = rn; bus.rm = rm; bus.shift = sh; bus.use_imm = ui; bus.imm = im; bus.zero_a = za;
      bus.start = 1'b1;
   endtask

   task automatic issue(input logic [2:0] rn, rm, input logic [1:0] sh, input logic ui, input logic [4:0] im,
                        input logic za, input logic rdw, input logic [15:0] rdw_d, input logic push);
      load(rn, rm, sh, ui, im, za, rdw, rdw_d, push);
      @(posedge clk); #1 bus.start = 1'b0;
      bus.rn = ~rn; bus.rm = ~rm; bus.shift = ~sh; bus.use_imm = ~ui; bus.imm = ~im; bus.zero_a = ~za;
      check("rda_busy", bus.busy, 1);
      check("rda_nvalid", bus.op_valid, 0);
      if (rdw) begin
         bus.wr_en = 1'b1; bus.wr_addr = rn; bus.wr_data = rdw_d;
         model[rn] = rdw_d;
      end
      @(posedge clk); #1 bus.wr_en = 1'b0;
      check("rdb_nvalid", bus.op_valid, 0);
   endtask

   task automatic run(input logic [2:0] rn, rm, input logic [1:0] sh, input logic ui, input logic [4:0] im,
                      input logic za, input logic rdw, input logic [15:0] rdw_d);
      issue(rn, rm, sh, ui, im, za, rdw, rdw_d, 1'b1);
      @(posedge clk); #1 check("latency", bus.op_valid, 1);
      @(posedge clk); #1 check("done_nvalid", bus.op_valid, 0);
      check("done_idle", bus.busy, 0);
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = 16'h0;
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.op_valid, 0);
      check("rst_ain", bus.ain, 0);
      check("rst_bin", bus.bin, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      bus.start = 0; bus.rn = 0; bus.rm = 0; bus.shift = 0; bus.use_imm = 0; bus.imm = 0; bus.zero_a = 0;
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.op_ready = 1;
      repeat (2) @(posedge clk);
      #1 reset_pulse();
      wr(3'd1, 16'h0005);
      wr(3'd2, 16'h0003);
      run(3'd1, 3'd2, 2'd0, 0, 5'd0, 0, 0, 16'h0);
      wr(3'd2, 16'h8001);
      for (int s = 0; s < 4; s++) run(3'd1, 3'd2, 2'(s), 0, 5'd0, 0, 0, 16'h0);
      run(3'd1, 3'd2, 2'd3, 1, 5'b10000, 0, 0, 16'h0);
      wr(3'd1, 16'h1234);
      run(3'd1, 3'd2, 2'd1, 0, 5'd0, 1, 0, 16'h0);
      run(3'd1, 3'd0, 2'd0, 1, 5'b01111, 0, 0, 16'h0);
      // backpressure: operands held, start in HOLD without ready ignored
      wr(3'd4, 16'hBEEF);
      wr(3'd5, 16'h7F00);
      bus.op_ready = 1'b0;
      issue(3'd4, 3'd5, 2'd2, 0, 5'd0, 0, 0, 16'h0, 1'b1);
      @(posedge clk); #1 check("bp_valid", bus.op_valid, 1);
      ha = bus.ain; hb = bus.bin;
      for (int c = 0; c < 4; c++) begin
         bus.start = (c == 1); bus.rn = 3'd1; bus.rm = 3'd2; bus.shift = 2'd0; bus.use_imm = 0; bus.zero_a = 0;
         @(posedge clk); #1 bus.start = 1'b0;
         check("bp_hold_valid", bus.op_valid, 1);
         check("bp_ain_stable", bus.ain, ha);
         check("bp_bin_stable", bus.bin, hb);
      end
      load(3'd5, 3'd4, 2'd1, 0, 5'd0, 0, 0, 16'h0, 1'b1);
      bus.op_ready = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      check("b2b_busy", bus.busy, 1);
      check("b2b_gap0", bus.op_valid, 0);
      @(posedge clk); #1 check("b2b_gap1", bus.op_valid, 0);
      @(posedge clk); #1 check("b2b_latency", bus.op_valid, 1);
      @(posedge clk); #1 check("b2b_done", bus.op_valid, 0);
      // read-during-write in RD_A
      wr(3'd1, 16'h0001);
      run(3'd1, 3'd1, 2'd0, 0, 5'd0, 0, 1, 16'h00FF);
      run(3'd1, 3'd1, 2'd0, 0, 5'd0, 0, 0, 16'h0);
      // reset mid-fetch (RD_B) and in HOLD
      wr(3'd3, 16'hABCD);
      issue(3'd3, 3'd3, 2'd0, 0, 5'd0, 0, 0, 16'h0, 1'b0);
      reset_pulse();
      wr(3'd3, 16'hABCD);
      wr(3'd6, 16'h5555);
      bus.op_ready = 1'b0;
      issue(3'd3, 3'd6, 2'd0, 0, 5'd0, 0, 0, 16'h0, 1'b0);
      @(posedge clk); #1 check("hold_reached", bus.op_valid, 1);
      bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 16'h9999;
      reset_pulse();
      bus.start = 1'b0; bus.wr_en = 1'b0; bus.op_ready = 1'b1;
      for (int i = 0; i < 8; i++) run(3'(i), 3'(7 - i), 2'd0, 0, 5'd0, 0, 0, 16'h0);
      repeat (2) @(posedge clk);
      #1 check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
